// File: rtl/duc_pkg.sv
// Shared definitions for the multi-channel DUC playback mixer: command codes,
// register offsets, control states and the output saturation helper.
package duc_pkg;

    localparam logic [15:0] CMD_START = 16'h5555;
    localparam logic [15:0] CMD_END   = 16'h8888;
    localparam logic [15:0] CMD_TRIG  = 16'hFFFF;
    localparam logic [15:0] CMD_STOP  = 16'hAAAA;
    localparam logic [15:0] CMD_CLR   = 16'h0001;

    localparam logic [1:0] REG_CMD  = 2'd0;
    localparam logic [1:0] REG_FW   = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_LOOP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_PLAY  = 2'd3
    } state_t;

    // Clamp a wide signed value into a dw-bit signed range (dw <= 16).
    function automatic logic signed [15:0] sat_dw(input logic signed [32:0] v, input int dw);
        logic signed [32:0] hi, lo;
        hi = (33'sd1 <<< (dw - 1)) - 33'sd1;
        lo = -hi - 33'sd1;
        if (v > hi)      return hi[15:0];
        else if (v < lo) return lo[15:0];
        else             return v[15:0];
    endfunction

endpackage

// File: rtl/duc_ofifo.sv
// Synchronous first-word-fall-through FIFO: dout shows the head entry while
// !empty; writes when full and reads when empty are ignored.
module duc_ofifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW:0]      wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/duc_play_mix.sv
// Multi-channel DUC playback: bus-loaded I/Q buffer replayed on phase-accumulator
// ticks, mixed per channel with its LO, saturated and streamed through a FIFO.
module duc_play_mix
    import duc_pkg::*;
#(
    parameter int                 DW        = 16,
    parameter int                 NCH       = 2,
    parameter int                 AW        = 12,
    parameter logic [13:0]        BUF_BASE  = 14'd12000,
    parameter logic [13:0]        REG_BASE  = 14'd16000,
    parameter logic signed [15:0] IDLE_VAL  = 16'sd3000,
    parameter int                 FRAME_LEN = 256,
    parameter int                 OFIFO_AW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lbs_we,
    input  logic [13:0]       lbs_addr,
    input  logic [31:0]       lbs_din,
    input  logic [NCH*DW-1:0] lo_cos,
    input  logic [NCH*DW-1:0] lo_sin,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [NCH*DW-1:0] m_tdata,
    output logic              m_tlast,
    output logic [31:0]       stat
);

    localparam int DEPTH  = 2**AW;
    localparam int SPC    = DEPTH / NCH;
    localparam int STAGES = NCH + 3;
    localparam int FCW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic        bus_we;
    logic [13:0] bus_addr;
    logic [31:0] bus_din;
    logic [14:0] buf_off;
    logic [1:0]  reg_sel;
    logic        is_reg, buf_hit, cmd_hit;
    logic        is_start, is_end, is_trig, is_stop, is_clr;

    state_t      state, state_nxt;
    logic [31:0] fw, acc;
    logic [32:0] acc_sum;
    logic [15:0] len_reg, loop_reg, len_eff, idx, loops_left;
    logic        stop_pend, stop_now, last_smp, ovf, wr_err, tick;

    logic [STAGES:1] vld_q;
    logic [STAGES:0] vld_pipe;
    logic [AW-1:0]   rd_ptr, rd_addr;
    logic            rd_en, play_t;
    logic [31:0]     ram [DEPTH];
    logic [31:0]     rdata;

    logic [NCH-1:0][DW-1:0] cos_r, sin_r, i_r, q_r, y_nxt, y_r;
    logic                   fifo_full, fifo_empty, hs;
    logic [FCW-1:0]         beat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_we   <= 1'b0;
            bus_addr <= '0;
            bus_din  <= '0;
        end else begin
            bus_we   <= lbs_we;
            bus_addr <= lbs_addr;
            bus_din  <= lbs_din;
        end
    end

    // The register window lies inside the buffer window at default parameters;
    // registers win, so those four buffer words are not bus-writable.
    assign is_reg   = (bus_addr >= REG_BASE) && (bus_addr <= REG_BASE + 14'd3);
    assign reg_sel  = bus_addr[1:0] - REG_BASE[1:0];
    assign buf_off  = {1'b0, bus_addr} - {1'b0, BUF_BASE};
    assign buf_hit  = bus_we && !is_reg && (bus_addr >= BUF_BASE) && (buf_off < 15'(DEPTH));
    assign cmd_hit  = bus_we && is_reg && (reg_sel == REG_CMD);
    assign is_start = cmd_hit && (bus_din[15:0] == CMD_START);
    assign is_end   = cmd_hit && (bus_din[15:0] == CMD_END);
    assign is_trig  = cmd_hit && (bus_din[15:0] == CMD_TRIG);
    assign is_stop  = cmd_hit && (bus_din[15:0] == CMD_STOP);
    assign is_clr   = cmd_hit && (bus_din[15:0] == CMD_CLR);

    assign acc_sum  = {1'b0, acc} + {1'b0, fw};
    assign tick     = acc_sum[32];
    assign len_eff  = (len_reg >= 16'(SPC)) ? 16'(SPC - 1) : len_reg;
    assign stop_now = stop_pend || is_stop;
    assign last_smp = (idx == len_eff) && (loops_left == 16'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (is_start) state_nxt = ST_LOAD;
            ST_LOAD:  if (is_end) state_nxt = ST_READY;
            ST_READY: begin
                if (is_start)     state_nxt = ST_LOAD;
                else if (is_trig) state_nxt = ST_PLAY;
            end
            ST_PLAY:  if (tick && (stop_now || last_smp)) state_nxt = ST_READY;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc        <= '0;
            fw         <= '0;
            len_reg    <= '0;
            loop_reg   <= '0;
            idx        <= '0;
            loops_left <= '0;
            stop_pend  <= 1'b0;
            ovf        <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_sum[31:0];
            if (bus_we && is_reg) begin
                case (reg_sel)
                    REG_FW:   fw       <= bus_din;
                    REG_LEN:  len_reg  <= bus_din[15:0];
                    REG_LOOP: loop_reg <= bus_din[15:0];
                    default: ;
                endcase
            end
            if (buf_hit && state == ST_PLAY)           wr_err <= 1'b1;
            if (vld_pipe[STAGES] && fifo_full)         ovf    <= 1'b1;
            if (is_clr) begin
                ovf    <= 1'b0;
                wr_err <= 1'b0;
            end
            if (state == ST_READY && is_trig) begin
                idx        <= '0;
                loops_left <= loop_reg;
                stop_pend  <= 1'b0;
            end else if (state == ST_PLAY) begin
                if (is_stop) stop_pend <= 1'b1;
                if (tick) begin
                    if (stop_now) begin
                        stop_pend <= 1'b0;
                    end else if (idx == len_eff) begin
                        // loops_left == 0 means endless replay
                        idx <= '0;
                        if (loops_left != 16'd0) loops_left <= loops_left - 16'd1;
                    end else begin
                        idx <= idx + 16'd1;
                    end
                end
            end
        end
    end

    // Stage k < NCH reads word idx*NCH+k; word k lands in rdata at stage k+1.
    assign vld_pipe = {vld_q, tick};
    assign rd_en    = |vld_pipe[NCH-1:0];
    assign rd_addr  = tick ? AW'(32'(idx) * NCH) : rd_ptr;

    always_ff @(posedge clk) begin
        if (buf_hit && state != ST_PLAY) ram[buf_off[AW-1:0]] <= bus_din;
        if (rd_en) rdata <= ram[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            rd_ptr <= '0;
            play_t <= 1'b0;
            cos_r  <= '0;
            sin_r  <= '0;
            i_r    <= '0;
            q_r    <= '0;
            y_r    <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (rd_en) rd_ptr <= rd_addr + 1'b1;
            if (tick) begin
                cos_r  <= lo_cos;
                sin_r  <= lo_sin;
                play_t <= (state == ST_PLAY) && !stop_now;
            end
            for (int k = 0; k < NCH; k++) begin
                if (vld_pipe[k+1]) begin
                    i_r[k] <= play_t ? rdata[DW-1:0]     : IDLE_VAL[DW-1:0];
                    q_r[k] <= play_t ? rdata[16+DW-1:16] : IDLE_VAL[DW-1:0];
                end
            end
            if (vld_pipe[NCH+2]) y_r <= y_nxt;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_mix
        logic signed [2*DW:0] pi, pq, p_r;
        logic signed [32:0]   sh;
        logic signed [15:0]   s16;

        assign pi  = $signed(i_r[c]) * $signed(cos_r[c]);
        assign pq  = $signed(q_r[c]) * $signed(sin_r[c]);
        assign sh  = 33'(p_r >>> (DW - 1));
        assign s16 = sat_dw(sh, DW);
        assign y_nxt[c] = s16[DW-1:0];

        always_ff @(posedge clk) begin
            if (rst)                  p_r <= '0;
            else if (vld_pipe[NCH+1]) p_r <= pi - pq;
        end
    end

    duc_ofifo #(.WIDTH(NCH*DW), .AW(OFIFO_AW)) u_ofifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (vld_pipe[STAGES]),
        .din   (y_r),
        .rd_en (m_tready),
        .dout  (m_tdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_tvalid = !fifo_empty;
    assign hs       = m_tvalid && m_tready;
    assign m_tlast  = (beat_cnt == FCW'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst)     beat_cnt <= '0;
        else if (hs) beat_cnt <= m_tlast ? '0 : beat_cnt + 1'b1;
    end

    assign stat = {ovf, wr_err, state, 12'd0, loops_left};

endmodule

// File: tb/tb_duc_play_mix.sv
// Randomized self-checking bench for duc_play_mix against a sample-level playback model.
module tb_duc_play_mix;

    localparam logic [13:0] BUF_BASE = 14'd12000;
    localparam logic [13:0] REG_BASE = 14'd16000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lbs_we;
    logic [13:0] lbs_addr;
    logic [31:0] lbs_din;
    logic [31:0] lo_cos, lo_sin;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic [31:0] stat;

    duc_play_mix dut (
        .clk      (clk),
        .rst      (rst),
        .lbs_we   (lbs_we),
        .lbs_addr (lbs_addr),
        .lbs_din  (lbs_din),
        .lo_cos   (lo_cos),
        .lo_sin   (lo_sin),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .stat     (stat)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_pass = 0, hs_cnt = 0, tlast_seen = 0;
    longint      cyc = 0;
    logic [31:0] beats[$];
    longint      bt[$];
    logic [31:0] expq[$];
    int          lc[2], ls[2], bi[64], bq[64];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc++;

    // Beats handshake at the next posedge; tlast expected on every 256th beat since reset.
    always @(negedge clk) begin
        if (rst) begin
            hs_cnt = 0;
        end else if (m_tvalid && m_tready) begin
            chk("tlast", m_tlast, (hs_cnt % 256) == 255);
            if (m_tlast) tlast_seen++;
            beats.push_back(m_tdata);
            bt.push_back(cyc);
            hs_cnt++;
        end
    end

    function automatic logic [15:0] mix(input int i, input int q, input int c, input int s);
        longint p = longint'(i) * c - longint'(q) * s;
        p = p >>> 15;
        if (p > 32767)       p = 32767;
        else if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    function automatic logic [31:0] idle_word();
        return {mix(3000, 3000, lc[1], ls[1]), mix(3000, 3000, lc[0], ls[0])};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [13:0] a, input logic [31:0] d);
        lbs_we = 1'b1; lbs_addr = a; lbs_din = d;
        cycles(1);
        lbs_we = 1'b0;
    endtask

    task automatic set_lo();
        lo_cos = {16'(lc[1]), 16'(lc[0])};
        lo_sin = {16'(ls[1]), 16'(ls[0])};
    endtask

    task automatic rand_lo();
        for (int c = 0; c < 2; c++) begin
            lc[c] = int'($urandom_range(32767, 8192));
            ls[c] = int'($urandom_range(16384, 0)) - 8192;
        end
        set_lo();
    endtask

    task automatic load_buf(input int len);
        for (int k = 0; k < 2 * (len + 1); k++) begin
            bi[k] = int'($urandom_range(65535, 0)) - 32768;
            bq[k] = int'($urandom_range(65535, 0)) - 32768;
        end
        bi[0] = -20000; bq[0] = 0;   // guarantees the first played beat differs from idle
        for (int k = 0; k < 2 * (len + 1); k++)
            bus_wr(BUF_BASE + 14'(k), {16'(bq[k]), 16'(bi[k])});
    endtask

    task automatic build_exp(input int len, input int loops);
        expq.delete();
        for (int l = 0; l < loops; l++)
            for (int s = 0; s <= len; s++)
                expq.push_back({mix(bi[2*s+1], bq[2*s+1], lc[1], ls[1]),
                                mix(bi[2*s],   bq[2*s],   lc[0], ls[0])});
    endtask

    // Expect: idle beats, then exactly the expected sequence, then idle again.
    task automatic analyze(input string tag);
        logic [31:0] idle = idle_word();
        int i = 0;
        while (i < beats.size() && beats[i] == idle) i++;
        chk({tag, "_len"}, (i + expq.size()) < beats.size(), 1);
        for (int j = 0; j < expq.size(); j++)
            if (i + j < beats.size()) chk({tag, "_data"}, beats[i+j], expq[j]);
        if (i + expq.size() < beats.size()) chk({tag, "_tail"}, beats[i+expq.size()], idle);
    endtask

    task automatic wait_state(input logic [1:0] st, input int bound, input string tag);
        int n = 0;
        while (stat[29:28] != st && n < bound) begin
            cycles(1);
            n++;
        end
        chk(tag, stat[29:28], st);
    endtask

    logic [31:0] d0;
    int          len, loops;

    initial begin
        lbs_we = 1'b0; lbs_addr = '0; lbs_din = '0; m_tready = 1'b1;
        lc[0] = 16384; lc[1] = 16384; ls[0] = 0; ls[1] = 0;
        set_lo();
        cycles(3);
        chk("rst_stat", stat, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        rst = 1'b0;
        cycles(2);

        // Idle replay: one beat per 64 cycles, both channels 3000*0.5
        beats.delete(); bt.delete();
        bus_wr(REG_BASE + 14'd1, 32'h0400_0000);
        cycles(400);
        chk("idle_cnt", beats.size() >= 4, 1);
        for (int j = 0; j < beats.size(); j++) chk("idle_val", beats[j], 32'h05DC_05DC);
        for (int j = 1; j < bt.size(); j++) chk("idle_period", bt[j] - bt[j-1], 64);

        // Randomized playback through LOAD/READY/PLAY with LOOP count
        bus_wr(REG_BASE + 14'd1, 32'h2000_0000);
        rand_lo();
        cycles(40);
        beats.delete();
        bus_wr(REG_BASE, 32'h5555);
        cycles(1);
        chk("load_state", stat[29:28], 2'd1);
        len   = int'($urandom_range(6, 1));
        loops = int'($urandom_range(3, 1));
        load_buf(len);
        bus_wr(REG_BASE, 32'h8888);
        bus_wr(REG_BASE + 14'd2, 32'(len));
        bus_wr(REG_BASE + 14'd3, 32'(loops));
        chk("ready_state", stat[29:28], 2'd2);
        bus_wr(REG_BASE, 32'hFFFF);
        cycles(2);
        chk("play_state", stat[29:28], 2'd3);
        chk("loops_load", stat[15:0], 16'(loops));
        wait_state(2'd2, 500, "play_done");
        chk("loops_left", stat[15:0], 0);
        cycles(60);
        build_exp(len, loops);
        analyze("play");

        // Saturation at both rails
        lc[0] = 32767; lc[1] = 32767; ls[0] = -32768; ls[1] = -32768;
        set_lo();
        cycles(40);
        beats.delete();
        bi[0] = 32767;  bq[0] = 32767;  bi[1] = 32767;  bq[1] = 32767;
        bi[2] = -32767; bq[2] = -32767; bi[3] = -32767; bq[3] = -32767;
        for (int k = 0; k < 4; k++) bus_wr(BUF_BASE + 14'(k), {16'(bq[k]), 16'(bi[k])});
        bus_wr(REG_BASE + 14'd2, 32'd1);
        bus_wr(REG_BASE + 14'd3, 32'd1);
        bus_wr(REG_BASE, 32'hFFFF);
        cycles(2);
        wait_state(2'd2, 300, "sat_done");
        cycles(60);
        build_exp(1, 1);
        chk("sat_pos_model", expq[0], 32'h7FFF_7FFF);
        chk("sat_neg_model", expq[1], 32'h8000_8000);
        analyze("sat");

        // Backpressure: FIFO fills, beats drop, ovf sticky until CLR
        m_tready = 1'b0;
        cycles(200);
        chk("ovf_set", stat[31], 1);
        chk("held_valid", m_tvalid, 1);
        d0 = m_tdata;
        chk("held_head", d0, idle_word());
        cycles(30);
        chk("held_data", m_tdata, d0);
        m_tready = 1'b1;
        cycles(1);
        bus_wr(REG_BASE, 32'h0001);
        cycles(2);
        chk("ovf_clr", stat[31], 0);
        for (int n = 0; n < 4000 && hs_cnt < 300; n++) cycles(1);
        chk("frame_reached", hs_cnt >= 300, 1);
        chk("tlast_seen", tlast_seen > 0, 1);

        // Endless play, write during PLAY, STOP
        rand_lo();
        cycles(40);
        load_buf(3);
        bus_wr(REG_BASE + 14'd2, 32'd3);
        bus_wr(REG_BASE + 14'd3, 32'd0);
        bus_wr(REG_BASE, 32'hFFFF);
        cycles(2);
        chk("inf_play", stat[29:28], 2'd3);
        cycles(30);
        bus_wr(BUF_BASE, 32'h1234_1234);
        cycles(1);
        chk("wr_err_set", stat[30], 1);
        bus_wr(REG_BASE, 32'hAAAA);
        wait_state(2'd2, 12, "stop_ready");
        cycles(40);
        beats.delete();
        cycles(100);
        chk("stop_idle_cnt", beats.size() >= 8, 1);
        for (int j = 0; j < beats.size(); j++) chk("stop_idle", beats[j], idle_word());
        bus_wr(REG_BASE, 32'h0001);
        cycles(2);
        chk("wr_err_clr", stat[30], 0);

        // Buffer must be unaffected by the dropped write
        beats.delete();
        bus_wr(REG_BASE + 14'd3, 32'd1);
        bus_wr(REG_BASE, 32'hFFFF);
        cycles(2);
        wait_state(2'd2, 300, "replay_done");
        cycles(60);
        build_exp(3, 1);
        analyze("ram_keep");

        // Reset in the middle of PLAY
        bus_wr(REG_BASE + 14'd3, 32'd0);
        bus_wr(REG_BASE, 32'hFFFF);
        cycles(30);
        chk("pre_rst_play", stat[29:28], 2'd3);
        rst = 1'b1;
        cycles(1);
        chk("mid_rst_stat", stat, 0);
        chk("mid_rst_tvalid", m_tvalid, 0);
        chk("mid_rst_tlast", m_tlast, 0);
        rst = 1'b0;
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/duc_play_mix.md
Name: duc_play_mix

Overview:
- Parametrised multi-channel successor to the single-channel DUC playback path.
- Local-bus writes load an interleaved I/Q baseband buffer and command registers.
- A phase-accumulator clock enable replays the buffer one-shot, N times or endlessly; each channel is mixed with its LO (I·cos − Q·sin) and saturated.
- Results go through an output FIFO to an AXI-stream with periodic tlast. Single clock domain.

Parameters:
- DW, 16, sample/LO width (I,Q packed {Q,I} in 32-bit word; DW≤16)
- NCH, 2, channel count (1..8)
- AW, 12, buffer word-address width (depth 2^AW)
- BUF_BASE, 14'd12000, first lbs address of buffer
- REG_BASE, 14'd16000, CMD at +0, FW at +1, LEN at +2, LOOP at +3
- IDLE_VAL, 16'sd3000, baseband I and Q value when not playing
- FRAME_LEN, 256, beats per tlast frame
- OFIFO_AW, 4, output FIFO depth 2^OFIFO_AW

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- lbs_we  in  1  bus write strobe
- lbs_addr  in  14  bus address
- lbs_din  in  32  bus write data
- lo_cos  in  NCH*DW  per-channel cosine, ch0 in LSBs
- lo_sin  in  NCH*DW  per-channel sine
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready
- m_tdata  out  NCH*DW  mixed samples, ch0 in LSBs
- m_tlast  out  1  last beat of frame
- stat  out  32  {ovf, wr_err, state[1:0], 12'd0, loops_left[15:0]}

Behaviour:
- Reset: all registers 0, state IDLE, m_tvalid/m_tlast 0, stat 0, FIFO empty, FW=0 (no ticks).
- Buffer writes: address in [BUF_BASE, BUF_BASE+2^AW−1] and lbs_we writes word at lbs_addr−BUF_BASE, one-cycle registered. Word k holds sample k/NCH of channel k%NCH.
- Writes while state==PLAY are dropped and set sticky wr_err.
- Registers: FW (32b tick increment), LEN (samples per channel minus 1, 16b), LOOP (0 = infinite, else play count).
- CMD codes: 0x5555 START, 0x8888 END, 0xFFFF TRIG, 0xAAAA STOP, 0x0001 CLR (clears ovf, wr_err). Other codes are ignored.
- FSM:
  - IDLE -START-> LOAD
  - LOAD -END-> READY
  - READY -START-> LOAD
  - READY -TRIG-> PLAY; loads loops_left=LOOP and sample index 0
  - PLAY -STOP-> READY, at the next tick boundary
  - PLAY -> READY after last sample of last loop; loops_left decrements at each wrap, infinite when LOOP=0
  - TRIG outside READY is ignored. START in PLAY is ignored.
- Tick: 32-bit accumulator acc+=FW every cycle; tick on carry-out. Ticks run in every state. Legal FW < 2^32/(NCH+4); larger FW is undefined.
- Per tick: sample LO inputs; read NCH consecutive words (1-cycle RAM latency).
  - If PLAY: I,Q come from the buffer.
  - Otherwise: I=Q=IDLE_VAL.
- Mix per channel: p = I·cos − Q·sin, 2DW+1 bits signed. Output = p>>>(DW−1), saturated to [−2^(DW−1), 2^(DW−1)−1].
- Tick to FIFO write: exactly NCH+3 cycles. One FIFO write per tick.
- FIFO full at write: beat dropped, ovf sticky set, tlast counter not advanced.
- Stream: m_tvalid = ~empty (first-word fall-through); data holds while tvalid & ~tready.
- tlast counter: 0..FRAME_LEN−1, advances on each handshake; m_tlast=1 when count==FRAME_LEN−1.
- Sample index wraps LEN→0. LEN ≥ 2^AW/NCH is clamped to 2^AW/NCH−1.

Decomposition:
- Package duc_pkg: command code constants, register offsets, state enum (IDLE, LOAD, READY, PLAY), saturate function.
- Sub-module duc_ofifo: synchronous FWFT FIFO, params width/AW, full/empty.

Test Plan:
- Reset, FW=2^32/64, NCH=2, no commands, lo_cos=16'h4000, lo_sin=0 → beat every 64 cycles, each channel = 1500.
- Load LEN=3 with I=1000·k, Q=0; START/END/TRIG, LOOP=2; cos=0x7FFF, sin=0 → ch samples ≈999,1999,2999,3999 twice. State returns READY; loops_left=0.
- I=Q=0x7FFF, cos=0x7FFF, sin=0x8000 → output saturates to 0x7FFF. Negated inputs → 0x8000.
- m_tready=0 for 20 ticks, OFIFO_AW=4 → 16 beats held, ovf=1. CLR clears it. tlast aligns on beat 255 after resume.
- LOOP=0, TRIG, STOP mid-buffer → READY within one tick; later beats = IDLE-value mix. A buffer write during PLAY sets wr_err and leaves RAM unchanged.
- rst asserted mid-PLAY → next cycle state IDLE, FIFO empty, m_tvalid=0, stat=0.
